// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter merging ALU and load/store writeback into the regfile.
// Define WB_ARB_RR_EN for round-robin on different-address contention.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy
);

  logic              r_full0;
  logic              r_full1;
  logic [ADDR_W-1:0] r_addr0;
  logic [ADDR_W-1:0] r_addr1;
  logic [DATA_W-1:0] r_data0;
  logic [DATA_W-1:0] r_data1;
  logic              r_older1;

  logic w_same;
  logic w_both;
  logic w_pick1;
  logic w_grant0;
  logic w_grant1;
  logic w_acc0;
  logic w_acc1;
  logic w_keep0;
  logic w_keep1;
  logic w_stay0;
  logic w_stay1;

  assign w_both = r_full0 && r_full1;
  assign w_same = (r_addr0 == r_addr1);

`ifdef WB_ARB_RR_EN
  logic r_rr1;

  assign w_pick1 = w_same ? r_older1 : r_rr1;

  // Pointer only moves on a true contention, so lone writers never skew it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr1 <= 1'b0;
    end else if (w_both && !w_same) begin
      r_rr1 <= w_grant0;
    end
  end
`else
  assign w_pick1 = w_same && r_older1;
`endif

  assign w_grant0 = r_full0 && (!r_full1 || !w_pick1);
  assign w_grant1 = r_full1 && !w_grant0;

  assign req0_ready = !rst && (!r_full0 || w_grant0);
  assign req1_ready = !rst && (!r_full1 || w_grant1);

  assign w_acc0  = req0_valid && req0_ready;
  assign w_acc1  = req1_valid && req1_ready;
  assign w_keep0 = w_acc0 && (req0_addr != '0);
  assign w_keep1 = w_acc1 && (req1_addr != '0);
  assign w_stay0 = r_full0 && !w_grant0;
  assign w_stay1 = r_full1 && !w_grant1;

  assign busy = r_full0 || r_full1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full0 <= 1'b0;
      r_addr0 <= '0;
      r_data0 <= '0;
    end else begin
      r_full0 <= w_keep0 || w_stay0;
      if (w_keep0) begin
        r_addr0 <= req0_addr;
        r_data0 <= req0_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full1 <= 1'b0;
      r_addr1 <= '0;
      r_data1 <= '0;
    end else begin
      r_full1 <= w_keep1 || w_stay1;
      if (w_keep1) begin
        r_addr1 <= req1_addr;
        r_data1 <= req1_data;
      end
    end
  end

  // r_older1 set means entry 1 predates entry 0; a same-edge pair ranks req0 older.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_older1 <= 1'b0;
    end else if (w_keep0 && w_keep1) begin
      r_older1 <= 1'b0;
    end else if (w_keep0) begin
      r_older1 <= w_stay1;
    end else if (w_keep1) begin
      r_older1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      we <= w_grant0 || w_grant1;
      if (w_grant0) begin
        waddr <= r_addr0;
        wdata <= r_data0;
      end else if (w_grant1) begin
        waddr <= r_addr1;
        wdata <= r_data1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against an age/queue reference model.
// Honours WB_ARB_RR_EN to pick the matching arbitration policy.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid;
  logic        req0_ready;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req1_valid;
  logic        req1_ready;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        busy;

  bit          in_v[2];
  logic [4:0]  in_a[2];
  logic [31:0] in_d[2];

  assign req0_valid = in_v[0];
  assign req0_addr  = in_a[0];
  assign req0_data  = in_d[0];
  assign req1_valid = in_v[1];
  assign req1_addr  = in_a[1];
  assign req1_data  = in_d[1];

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: buffers with acceptance sequence numbers for age.
  bit          m_full[2];
  logic [4:0]  m_addr[2];
  logic [31:0] m_data[2];
  int          m_seq[2];
  int          seq_ctr;
  bit          m_turn;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_rf[32];
  logic [31:0] d_rf[32];
  bit          last_acc[2];
  logic [4:0]  exp3[4];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_full[i]   = 1'b0;
      m_seq[i]    = 0;
      last_acc[i] = 1'b0;
    end
    m_turn  = 1'b0;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  function automatic int pick();
    if (!m_full[0] && !m_full[1]) return -1;
    if (!m_full[1]) return 0;
    if (!m_full[0]) return 1;
    if (m_addr[0] == m_addr[1]) return (m_seq[0] < m_seq[1]) ? 0 : 1;
`ifdef WB_ARB_RR_EN
    return m_turn ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic step();
    int g;
    bit rdy[2];
    bit both_diff;
    g = pick();
    rdy[0] = !m_full[0] || (g == 0);
    rdy[1] = !m_full[1] || (g == 1);
    #1;
    chk("req0_ready", req0_ready, rdy[0]);
    chk("req1_ready", req1_ready, rdy[1]);
    chk("busy_pre", busy, m_full[0] | m_full[1]);
    @(posedge clk);
    both_diff = m_full[0] && m_full[1] && (m_addr[0] != m_addr[1]);
    if (g >= 0) begin
      m_we    = 1'b1;
      m_waddr = m_addr[g];
      m_wdata = m_data[g];
      m_full[g] = 1'b0;
      if (both_diff) m_turn = (g == 0);
    end else begin
      m_we = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      last_acc[i] = in_v[i] && rdy[i];
      if (last_acc[i] && in_a[i] != 5'd0) begin
        m_full[i] = 1'b1;
        m_addr[i] = in_a[i];
        m_data[i] = in_d[i];
        m_seq[i]  = seq_ctr++;
      end
    end
    if (m_we) m_rf[m_waddr] = m_wdata;
    #1;
    chk("we", we, m_we);
    chk("waddr", waddr, m_waddr);
    chk("wdata", wdata, m_wdata);
    chk("busy", busy, m_full[0] | m_full[1]);
    if (we === 1'b1) d_rf[waddr] = wdata;
  endtask

  task automatic do_reset();
    in_v[0] = 1'b0;
    in_v[1] = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_we", we, 1'b0);
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_v[i] = 1'b0;
      in_a[i] = '0;
      in_d[i] = '0;
    end
    for (int i = 0; i < 32; i++) begin
      m_rf[i] = '0;
      d_rf[i] = '0;
    end
    seq_ctr = 1;
    model_reset();
    rst = 1'b1;
    #2;
    chk("reset_we", we, 1'b0);
    chk("reset_waddr", waddr, 5'd0);
    chk("reset_wdata", wdata, 32'd0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ready0", req0_ready, 1'b0);
    chk("reset_ready1", req1_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release_ready0", req0_ready, 1'b1);
    chk("release_ready1", req1_ready, 1'b1);

    // Single write latency
    in_v[0] = 1'b1; in_a[0] = 5'd3; in_d[0] = 32'hDEADBEEF;
    step();
    in_v[0] = 1'b0;
    step();
    chk("lat_we", we, 1'b1);
    chk("lat_waddr", waddr, 5'd3);
    chk("lat_wdata", wdata, 32'hDEADBEEF);
    step();
    chk("lat_we_drop", we, 1'b0);

    // Same-address same-edge ordering
    in_v[0] = 1'b1; in_a[0] = 5'd5; in_d[0] = 32'h11;
    in_v[1] = 1'b1; in_a[1] = 5'd5; in_d[1] = 32'h22;
    step();
    in_v[0] = 1'b0; in_v[1] = 1'b0;
    step();
    chk("age_first", wdata, 32'h11);
    step();
    chk("age_second_we", we, 1'b1);
    chk("age_second", wdata, 32'h22);
    step();
    chk("age_rf5", d_rf[5], 32'h22);

    // Sustained different-address contention
`ifdef WB_ARB_RR_EN
    exp3[0] = 5'd1; exp3[1] = 5'd2; exp3[2] = 5'd1; exp3[3] = 5'd2;
`else
    exp3[0] = 5'd1; exp3[1] = 5'd1; exp3[2] = 5'd1; exp3[3] = 5'd1;
`endif
    in_v[0] = 1'b1; in_a[0] = 5'd1; in_d[0] = 32'hA1;
    in_v[1] = 1'b1; in_a[1] = 5'd2; in_d[1] = 32'hB2;
    step();
    for (int k = 0; k < 4; k++) begin
`ifndef WB_ARB_RR_EN
      chk("fixed_ready1", req1_ready, 1'b0);
`endif
      step();
      chk("cont_waddr", waddr, exp3[k]);
    end
    in_v[0] = 1'b0; in_v[1] = 1'b0;
    for (int k = 0; k < 6; k++) step();

    // x0 discard
    in_v[1] = 1'b1; in_a[1] = 5'd0; in_d[1] = 32'hFFFFFFFF;
    #1;
    chk("x0_ready", req1_ready, 1'b1);
    step();
    in_v[1] = 1'b0;
    chk("x0_busy", busy, 1'b0);
    step();
    chk("x0_we", we, 1'b0);
    chk("x0_busy2", busy, 1'b0);

    // Reset with both buffers full
    in_v[0] = 1'b1; in_a[0] = 5'd7; in_d[0] = 32'h70;
    in_v[1] = 1'b1; in_a[1] = 5'd9; in_d[1] = 32'h90;
    step();
    step();
    chk("pre_rst_we", we, 1'b1);
    chk("pre_rst_busy", busy, 1'b1);
    do_reset();
    step();
    chk("post_rst_we", we, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    step();
    chk("post_rst_we2", we, 1'b0);

    // Streaming from req0
    for (int k = 1; k <= 8; k++) begin
      in_v[0] = 1'b1; in_a[0] = 5'(k); in_d[0] = 32'h100 + k;
      chk("stream_ready", req0_ready, 1'b1);
      step();
      if (k >= 2) begin
        chk("stream_we", we, 1'b1);
        chk("stream_waddr", waddr, 5'(k - 1));
      end
    end
    in_v[0] = 1'b0;
    step();
    chk("stream_last_we", we, 1'b1);
    chk("stream_last_addr", waddr, 5'd8);
    step();
    chk("stream_end_we", we, 1'b0);

    // Randomized traffic honouring the hold-while-stalled rule
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      for (int i = 0; i < 2; i++) begin
        if (!(in_v[i] && !last_acc[i])) begin
          in_v[i] = ($urandom_range(0, 3) != 0);
          in_a[i] = 5'($urandom_range(0, 7));
          in_d[i] = $urandom;
        end
      end
      step();
    end
    in_v[0] = 1'b0; in_v[1] = 1'b0;
    for (int k = 0; k < 6; k++) step();
    for (int i = 1; i < 32; i++) chk("rf_final", d_rf[i], m_rf[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
